// File: rtl/mips_pkg.sv
// mips_pkg: constants and entry type shared by the store buffer and the dmem interface
package mips_pkg;
  localparam int SWB_DEPTH = 4;
  localparam int SWB_AW = 32;
  localparam int SWB_DW = 32;
  typedef struct packed {
    logic [SWB_AW-1:0] addr;
    logic [SWB_DW-1:0] data;
  } store_entry_t;
endpackage

// File: rtl/swb_match.sv
// swb_match: word-address snoop across pending stores, youngest match wins
module swb_match
  import mips_pkg::*;
#(
  parameter int DEPTH = SWB_DEPTH,
  parameter int TW = SWB_AW - 2
) (
  input  logic [DEPTH-1:0]         valid,
  input  logic [TW-1:0]            tags [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] head,
  input  logic [TW-1:0]            ld_tag,
  output logic                     hit,
  output logic [$clog2(DEPTH)-1:0] idx
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] pos;
  // walk oldest to youngest so the last match seen is the youngest
  always_comb begin
    hit = 1'b0;
    idx = '0;
    pos = '0;
    for (int k = 0; k < DEPTH; k++) begin
      pos = head + PW'(k);
      if (valid[pos] && tags[pos] == ld_tag) begin
        hit = 1'b1;
        idx = pos;
      end
    end
  end
endmodule

// File: rtl/store_write_buffer.sv
// store_write_buffer: in-order store FIFO to the data bus with store-to-load forwarding
module store_write_buffer
  import mips_pkg::*;
#(
  parameter int DEPTH = SWB_DEPTH,
  parameter int AW = SWB_AW,
  parameter int DW = SWB_DW
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cpu_we,
  input  logic [AW-1:0]              cpu_addr,
  input  logic [DW-1:0]              cpu_wdata,
  output logic                       cpu_stall,
  input  logic [AW-1:0]              ld_addr,
  output logic                       ld_hit,
  output logic [DW-1:0]              ld_data,
  output logic                       bus_valid,
  input  logic                       bus_ready,
  output logic [AW-1:0]              bus_addr,
  output logic [DW-1:0]              bus_wdata,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [AW-3:0] tags [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0] head, tail, idx;
  logic [CW-1:0] count_q;
  logic full, push, pop, unused_lsb;
  assign full = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
  assign push = cpu_we && !full;
  assign pop = bus_valid && bus_ready;
  assign cpu_stall = full && cpu_we;
  assign bus_valid = !empty;
  assign bus_addr = bus_valid ? addr_q[head] : '0;
  assign bus_wdata = bus_valid ? data_q[head] : '0;
  assign ld_data = ld_hit ? data_q[idx] : '0;
  assign unused_lsb = ^ld_addr[1:0];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (push) begin
        tail <= tail + PW'(1);
        valid_q[tail] <= 1'b1;
      end
      if (pop) begin
        head <= head + PW'(1);
        valid_q[head] <= 1'b0;
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end
  // payload needs no reset: every read is qualified by valid/count
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= cpu_addr;
      data_q[tail] <= cpu_wdata;
    end
  end
  always_comb begin
    for (int i = 0; i < DEPTH; i++) tags[i] = addr_q[i][AW-1:2];
  end
  swb_match #(.DEPTH(DEPTH), .TW(AW - 2)) u_match (
    .valid(valid_q),
    .tags(tags),
    .head(head),
    .ld_tag(ld_addr[AW-1:2]),
    .hit(ld_hit),
    .idx(idx)
  );
endmodule

// File: tb/tb_store_write_buffer.sv
// tb_store_write_buffer: directed checks of fill/stall, ordering, forwarding and reset
module tb_store_write_buffer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, ld_addr = '0;
  logic cpu_stall, ld_hit, bus_valid, empty;
  logic bus_ready = 1'b0;
  logic [31:0] ld_data, bus_addr, bus_wdata;
  logic [2:0] count;
  int errors = 0;
  int checks = 0;

  store_write_buffer dut (
    .clk(clk), .reset(reset), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    cpu_we = 1'b1;
    cpu_addr = a;
    cpu_wdata = d;
    tick();
    cpu_we = 1'b0;
  endtask

  initial begin
    #12;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_valid", bus_valid, 0);
    check("rst_stall", cpu_stall, 0);
    check("rst_hit", ld_hit, 0);
    check("rst_addr", bus_addr, 0);
    @(negedge clk) reset = 1'b1;
    tick();

    // reset while stores are pending
    push(32'h200, 32'h1);
    push(32'h204, 32'h2);
    push(32'h208, 32'h3);
    check("pre_rst_count", count, 3);
    check("pre_rst_addr", bus_addr, 32'h200);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", bus_valid, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_wdata", bus_wdata, 0);
    @(negedge clk) reset = 1'b1;
    tick();
    bus_ready = 1'b1;
    ld_addr = 32'h200;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("post_rst_valid", bus_valid, 0);
      check("post_rst_hit", ld_hit, 0);
      tick();
    end
    bus_ready = 1'b0;

    // fill to full, stall, then one drain lets the stalled store in
    for (int i = 0; i < 4; i++) push(32'h10 + 32'(4 * i), 32'(i + 1));
    check("full_count", count, 4);
    cpu_we = 1'b1;
    cpu_addr = 32'h20;
    cpu_wdata = 32'h5;
    #1;
    check("full_stall", cpu_stall, 1);
    bus_ready = 1'b1;
    #1;
    check("full_stall_ready", cpu_stall, 1);
    check("full_head", bus_addr, 32'h10);
    tick();
    bus_ready = 1'b0;
    #1;
    check("after_pop_count", count, 3);
    check("after_pop_stall", cpu_stall, 0);
    check("after_pop_head", bus_addr, 32'h14);
    tick();
    cpu_we = 1'b0;
    check("refill_count", count, 4);
    bus_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain_addr", bus_addr, 32'h14 + 32'(4 * i));
      check("drain_data", bus_wdata, 32'(i + 2));
      tick();
    end
    check("drain_empty", empty, 1);
    bus_ready = 1'b0;

    // ordering and hold under back-pressure
    push(32'h40, 32'hAAAA0001);
    push(32'h44, 32'hBBBB0002);
    check("hold0_addr", bus_addr, 32'h40);
    tick();
    check("hold1_addr", bus_addr, 32'h40);
    check("hold1_data", bus_wdata, 32'hAAAA0001);
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    #1;
    check("second_addr", bus_addr, 32'h44);
    check("second_data", bus_wdata, 32'hBBBB0002);
    tick();
    check("second_hold", bus_wdata, 32'hBBBB0002);
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    #1;
    check("order_empty", empty, 1);
    check("order_valid", bus_valid, 0);

    // youngest-match forwarding
    push(32'h80, 32'h11);
    push(32'h84, 32'h22);
    push(32'h80, 32'h33);
    ld_addr = 32'h82;
    #1;
    check("fwd_hit", ld_hit, 1);
    check("fwd_young", ld_data, 32'h33);
    ld_addr = 32'h84;
    #1;
    check("fwd_mid", ld_data, 32'h22);
    ld_addr = 32'h88;
    #1;
    check("fwd_miss_hit", ld_hit, 0);
    check("fwd_miss_data", ld_data, 0);
    ld_addr = 32'h80;
    bus_ready = 1'b1;
    tick();
    tick();
    check("fwd_after2_data", ld_data, 32'h33);
    tick();
    bus_ready = 1'b0;
    #1;
    check("fwd_drained_hit", ld_hit, 0);

    // continuous push+pop at count=1 across pointer wrap
    push(32'h300, 32'h0);
    bus_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cpu_we = 1'b1;
      cpu_addr = 32'h304 + 32'(4 * k);
      cpu_wdata = 32'(k + 1);
      #1;
      check("pp_count", count, 1);
      check("pp_addr", bus_addr, k == 0 ? 32'h300 : 32'h304 + 32'(4 * (k - 1)));
      check("pp_data", bus_wdata, 32'(k));
      tick();
    end
    cpu_we = 1'b0;
    #1;
    check("pp_last", bus_addr, 32'h328);
    tick();
    check("pp_empty", empty, 1);
    bus_ready = 1'b0;

    // enqueue is invisible to the snoop until after its edge
    cpu_we = 1'b1;
    cpu_addr = 32'h100;
    cpu_wdata = 32'h5;
    ld_addr = 32'h100;
    #1;
    check("same_cycle_hit", ld_hit, 0);
    tick();
    cpu_we = 1'b0;
    check("next_cycle_hit", ld_hit, 1);
    check("next_cycle_data", ld_data, 32'h5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
